// File: rtl/alu_flag_reg.sv
// Z80-style flag register: main/alternate F banks, POP AF load, two-pass 16-bit Z chaining
// and condition-code evaluation for the ALU combiner's next-flag outputs.
module alu_flag_reg #(
    parameter logic [7:0] F_RST = 8'h00
) (
    input  logic       clkc,
    input  logic       resetb,
    input  logic       cry_nxt,
    input  logic       hcar_nxt,
    input  logic       one_nxt,
    input  logic       par_nxt,
    input  logic       sign_nxt,
    input  logic       zero_nxt,
    input  logic       vflo_nxt,
    input  logic       pv_sel,
    input  logic       sub_op,
    input  logic       flg_wr,
    input  logic [5:0] flg_msk,
    input  logic       pass_lo,
    input  logic       ld_flg,
    input  logic [7:0] data_bus,
    input  logic       ex_af,
    input  logic [2:0] cond_sel,
    output logic [7:0] flags,
    output logic       alt_bank,
    output logic       one_flg,
    output logic       cond_true,
    output logic       word_busy
);

    localparam logic [7:0] F_MASK = 8'hD7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HI   = 1'b1
    } word_st_e;

    word_st_e   st_q, st_d;
    logic [7:0] bank0_q, bank0_d;
    logic [7:0] bank1_q, bank1_d;
    logic [7:0] flags_q, flags_d;
    logic       alt_q, alt_d;
    logic       one_q, one_d;
    logic       zlo_q, zlo_d;

    logic [7:0] act_s;
    logic [7:0] new_s;
    logic [7:0] wmask_s;
    logic [7:0] upd_s;
    logic       pv_s;
    logic       z_s;

    // Next-state for banks, word-op FSM, low-pass zero and one flag.
    always_comb begin
        st_d    = st_q;
        zlo_d   = zlo_q;
        one_d   = one_q;
        act_s   = alt_q ? bank1_q : bank0_q;
        upd_s   = act_s;
        pv_s    = pv_sel ? vflo_nxt : par_nxt;
        z_s     = (st_q == ST_HI) ? (zero_nxt & zlo_q) : zero_nxt;
        new_s   = {sign_nxt, z_s, 1'b0, hcar_nxt, 1'b0, pv_s, sub_op, cry_nxt};
        // Low pass of a word op may only touch H, N and C.
        if (pass_lo) begin
            wmask_s = {1'b0, 1'b0, 1'b0, flg_msk[3], 1'b0, 1'b0, flg_msk[1], flg_msk[0]};
        end else begin
            wmask_s = {flg_msk[5], flg_msk[4], 1'b0, flg_msk[3], 1'b0,
                       flg_msk[2], flg_msk[1], flg_msk[0]};
        end

        if (ld_flg) begin
            upd_s = data_bus & F_MASK;
            st_d  = ST_IDLE;
        end else if (flg_wr) begin
            upd_s = (act_s & ~wmask_s) | (new_s & wmask_s);
            if (pass_lo) begin
                zlo_d = zero_nxt;
                st_d  = ST_HI;
            end else begin
                one_d = (st_q == ST_HI) ? 1'b0 : one_nxt;
                st_d  = ST_IDLE;
            end
        end else begin
            upd_s = act_s;
        end

        // Writes target the bank active before any same-cycle swap.
        bank0_d = alt_q ? bank0_q : (upd_s & F_MASK);
        bank1_d = alt_q ? (upd_s & F_MASK) : bank1_q;
        alt_d   = alt_q ^ ex_af;
        flags_d = alt_d ? bank1_d : bank0_d;
    end

    // State registers.
    always_ff @(posedge clkc or negedge resetb) begin
        if (!resetb) begin
            st_q    <= ST_IDLE;
            bank0_q <= F_RST & F_MASK;
            bank1_q <= F_RST & F_MASK;
            flags_q <= F_RST & F_MASK;
            alt_q   <= 1'b0;
            one_q   <= 1'b0;
            zlo_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            bank0_q <= bank0_d;
            bank1_q <= bank1_d;
            flags_q <= flags_d;
            alt_q   <= alt_d;
            one_q   <= one_d;
            zlo_q   <= zlo_d;
        end
    end

    // Condition codes from the currently visible flags.
    always_comb begin
        case (cond_sel)
            3'd0:    cond_true = ~flags_q[6];
            3'd1:    cond_true =  flags_q[6];
            3'd2:    cond_true = ~flags_q[0];
            3'd3:    cond_true =  flags_q[0];
            3'd4:    cond_true = ~flags_q[2];
            3'd5:    cond_true =  flags_q[2];
            3'd6:    cond_true = ~flags_q[7];
            3'd7:    cond_true =  flags_q[7];
            default: cond_true = 1'b0;
        endcase
    end

    assign flags     = flags_q;
    assign alt_bank  = alt_q;
    assign one_flg   = one_q;
    assign word_busy = (st_q == ST_HI);

endmodule
